// File: rtl/demux_1_4_pkg.sv
// Shared types, sizes and helpers for the demux_1_4 steering block.
// The lane-select encoding and the optional counter width are defined here.
package demux_1_4_pkg;

    localparam int NUM_OUT = 4;
    localparam int SEL_W   = 2;
    localparam int CNT_W   = 16;

    typedef logic [SEL_W-1:0] sel_t;

    function automatic logic [3:0] onehot4(input sel_t sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/demux_lane_cnt.sv
// Saturating beat counter for one demux lane; holds at all-ones instead of wrapping.
module demux_lane_cnt
    import demux_1_4_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/demux_1_4.sv
// Registered 1-to-4 demultiplexer: d is steered to lane s, other lanes are zero.
// Define DEMUX_1_4_CNT_EN to add lane_cnt, four saturating per-lane beat counters.
module demux_1_4
    import demux_1_4_pkg::*;
#(
    parameter int DATA_W  = 1,
    parameter int NUM_OUT = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         d,
    input  sel_t                      s,
    input  logic                      in_valid,
    output logic [NUM_OUT*DATA_W-1:0] y,
    output logic [NUM_OUT-1:0]        y_valid
`ifdef DEMUX_1_4_CNT_EN
    ,
    output logic [NUM_OUT*CNT_W-1:0]  lane_cnt
`endif
);

    if (NUM_OUT != demux_1_4_pkg::NUM_OUT) begin : g_bad_num_out
        $error("demux_1_4 supports exactly 4 output lanes");
    end

    logic [NUM_OUT*DATA_W-1:0] y_next;
    logic [NUM_OUT-1:0]        y_valid_next;

    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        y_next       = '0;
        y_valid_next = '0;
        if (in_valid) begin
            y_valid_next = onehot4(s);
            for (int k = 0; k < NUM_OUT; k++) begin
                if (s == sel_t'(k)) begin
                    y_next[k*DATA_W +: DATA_W] = d;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y       <= '0;
            y_valid <= '0;
        end else begin
            y       <= y_next;
            y_valid <= y_valid_next;
        end
    end

`ifdef DEMUX_1_4_CNT_EN
    for (genvar k = 0; k < NUM_OUT; k++) begin : g_cnt
        demux_lane_cnt u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (in_valid && (s == sel_t'(k))),
            .cnt   (lane_cnt[k*CNT_W +: CNT_W])
        );
    end
`endif

    // An unknown select on a valid beat would steer data to an undefined lane.
    a_sel_known : assert property (@(posedge clk) disable iff (!rst_n)
        in_valid |-> !$isunknown(s));

endmodule

// File: tb/tb_demux_1_4.sv
// Self-checking bench for demux_1_4 at DATA_W=1 and DATA_W=8 side by side.
// Lane counters are checked too when DEMUX_1_4_CNT_EN is defined.
`timescale 1ns/1ps
module tb_demux_1_4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  s = 2'd0;
    logic        d1 = 1'b0;
    logic [7:0]  d8 = 8'h00;
    logic [3:0]  y1, yv1, yv8;
    logic [31:0] y8;
`ifdef DEMUX_1_4_CNT_EN
    logic [63:0] cnt1, cnt8;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    demux_1_4 #(.DATA_W(1), .NUM_OUT(4)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .d        (d1),
        .s        (s),
        .in_valid (in_valid),
        .y        (y1),
        .y_valid  (yv1)
`ifdef DEMUX_1_4_CNT_EN
        ,
        .lane_cnt (cnt1)
`endif
    );

    demux_1_4 #(.DATA_W(8), .NUM_OUT(4)) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .d        (d8),
        .s        (s),
        .in_valid (in_valid),
        .y        (y8),
        .y_valid  (yv8)
`ifdef DEMUX_1_4_CNT_EN
        ,
        .lane_cnt (cnt8)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: what the outputs must hold after each edge, by plain arithmetic.
    logic [3:0]  m_y1, m_yv;
    logic [31:0] m_y8;
    int          m_cnt [4];
    bit          m_ok = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_y1 = '0; m_y8 = '0; m_yv = '0;
            for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        end else if (in_valid) begin
            m_yv = 4'(1 << s);
            m_y1 = 4'(d1) << s;
            m_y8 = 32'(d8) << (8 * s);
            if (m_cnt[s] < 65535) m_cnt[s] = m_cnt[s] + 1;
        end else begin
            m_y1 = '0; m_y8 = '0; m_yv = '0;
        end
        m_ok = 1'b1;
    end

    function automatic logic [63:0] model_cnt();
        logic [63:0] r = '0;
        for (int k = 0; k < 4; k++) r[k*16 +: 16] = 16'(m_cnt[k]);
        return r;
    endfunction

    always @(negedge clk) begin
        if (m_ok) begin
            check("cyc_y_w1",  64'(y1),  64'(m_y1));
            check("cyc_yv_w1", 64'(yv1), 64'(m_yv));
            check("cyc_y_w8",  64'(y8),  64'(m_y8));
            check("cyc_yv_w8", 64'(yv8), 64'(m_yv));
`ifdef DEMUX_1_4_CNT_EN
            check("cyc_cnt_w1", cnt1, model_cnt());
            check("cyc_cnt_w8", cnt8, model_cnt());
`endif
        end
    end

    task automatic drive(input logic r, input logic v, input logic a1,
                         input logic [7:0] a8, input logic [1:0] sel);
        @(negedge clk);
        rst_n = r; in_valid = v; d1 = a1; d8 = a8; s = sel;
    endtask

    // One beat, then hand-computed expectations checked against both DUTs and the model.
    task automatic step(input string name, input logic r, input logic v, input logic a1,
                        input logic [7:0] a8, input logic [1:0] sel,
                        input logic [3:0] e_y1, input logic [3:0] e_yv, input logic [31:0] e_y8);
        drive(r, v, a1, a8, sel);
        @(posedge clk);
        #1;
        check({name, "_y1"},  64'(y1),  64'(e_y1));
        check({name, "_yv1"}, 64'(yv1), 64'(e_yv));
        check({name, "_y8"},  64'(y8),  64'(e_y8));
        check({name, "_yv8"}, 64'(yv8), 64'(e_yv));
        check({name, "_model"}, {m_y8, m_yv, m_y1}, {e_y8, e_yv, e_y1});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) step("reset", 0, 1, 1, 8'hFF, 2'd2, 4'h0, 4'h0, 32'h0);

        step("sweep0", 1, 1, 0, 8'h00, 2'd0, 4'b0000, 4'b0001, 32'h0000_0000);
        step("sweep1", 1, 1, 1, 8'h5A, 2'd0, 4'b0001, 4'b0001, 32'h0000_005A);
        step("sweep2", 1, 1, 0, 8'h00, 2'd1, 4'b0000, 4'b0010, 32'h0000_0000);
        step("sweep3", 1, 1, 1, 8'h5A, 2'd1, 4'b0010, 4'b0010, 32'h0000_5A00);
        step("sweep4", 1, 1, 0, 8'h00, 2'd2, 4'b0000, 4'b0100, 32'h0000_0000);
        step("sweep5", 1, 1, 1, 8'h5A, 2'd2, 4'b0100, 4'b0100, 32'h005A_0000);
        step("sweep6", 1, 1, 0, 8'h00, 2'd3, 4'b0000, 4'b1000, 32'h0000_0000);
        step("sweep7", 1, 1, 1, 8'h5A, 2'd3, 4'b1000, 4'b1000, 32'h5A00_0000);

        step("idle",   1, 0, 1, 8'hFF, 2'd3, 4'b0000, 4'b0000, 32'h0000_0000);

        step("b2b_a5", 1, 1, 1, 8'hA5, 2'd1, 4'b0010, 4'b0010, 32'h0000_A500);
        step("b2b_3c", 1, 1, 0, 8'h3C, 2'd2, 4'b0000, 4'b0100, 32'h003C_0000);

        step("mid_pre", 1, 1, 1, 8'h11, 2'd3, 4'b1000, 4'b1000, 32'h1100_0000);
        step("mid_rst", 0, 1, 1, 8'h22, 2'd0, 4'b0000, 4'b0000, 32'h0000_0000);
        step("mid_post", 1, 1, 1, 8'h33, 2'd0, 4'b0001, 4'b0001, 32'h0000_0033);

`ifdef DEMUX_1_4_CNT_EN
        step("cnt_rst", 0, 0, 0, 8'h00, 2'd0, 4'h0, 4'h0, 32'h0);
        check("cnt_clear", cnt1, 64'h0);
        for (int i = 0; i < 5; i++) drive(1, 1, 1, 8'h01, 2'd3);
        for (int i = 0; i < 2; i++) drive(1, 1, 1, 8'h01, 2'd0);
        drive(1, 0, 0, 8'h00, 2'd0);
        @(posedge clk); #1;
        check("cnt_5_2_w1", cnt1, 64'h0005_0000_0000_0002);
        check("cnt_5_2_w8", cnt8, 64'h0005_0000_0000_0002);
        for (int i = 0; i < 65534; i++) drive(1, 1, 0, 8'h00, 2'd1);
        drive(1, 0, 0, 8'h00, 2'd1);
        @(posedge clk); #1;
        check("cnt_fffe", cnt1, 64'h0005_0000_FFFE_0002);
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 8'h00, 2'd1);
        drive(1, 0, 0, 8'h00, 2'd1);
        @(posedge clk); #1;
        check("cnt_sat_w1", cnt1, 64'h0005_0000_FFFF_0002);
        check("cnt_sat_w8", cnt8, 64'h0005_0000_FFFF_0002);
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_1_4.md
Name: demux_1_4

Overview:
- Registered 1-to-4 demultiplexer. Routes the data input `d` to one of four output lanes `y`, chosen by the 2-bit select `s`.
- All non-selected lanes are driven to zero.
- Used as a generic steering element in datapath fan-out.
- Output is registered with a 1-cycle latency and carries a per-lane valid strobe.

Parameters:
- DATA_W, 1, width of `d` and of each output lane.
- NUM_OUT, 4, number of output lanes. Fixed at 4; any other value is rejected at elaboration.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- d  input  DATA_W  data to route.
- s  input  2  lane select: 0 selects y lane 0, 3 selects y lane 3.
- in_valid  input  1  qualifies `d` and `s` this cycle.
- y  output  4*DATA_W  flattened lanes; lane k occupies bits [k*DATA_W +: DATA_W].
- y_valid  output  4  one-hot valid; bit k high means lane k carries data this cycle.

Behaviour:
- Reset: on a clock edge with rst_n=0, y is set to all zeros and y_valid to 0000. Reset overrides in_valid on the same edge.
- Normal update, every edge with rst_n=1 and in_valid=1:
  - lane[s] <= d.
  - All other lanes <= 0.
  - y_valid <= one-hot(s).
- Edge with rst_n=1 and in_valid=0: all lanes <= 0 and y_valid <= 0000. There is no hold of the previous data.
- Latency: exactly 1 cycle from sampled inputs to y and y_valid. Full throughput, one beat per cycle, no backpressure.
- With d=0 and a valid select, lane[s] is 0 but y_valid[s] is still 1. Consumers must use y_valid, not data, to detect routing.
- y_valid is always zero-hot or one-hot.
- X/Z on `s` while in_valid=1 is illegal. Simulation assertion: with in_valid=1, `s` has no X/Z.
- Deasserting reset mid-stream: the first edge after rst_n returns to 1 processes inputs normally. No warm-up cycle.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro DEMUX_1_4_CNT_EN.
- When defined:
  - Adds output `lane_cnt`, width 4*16, holding four 16-bit counters.
  - Counter k increments on each edge where in_valid=1, rst_n=1 and s==k.
  - Counters saturate at 16'hFFFF and do not wrap.
  - Reset clears all counters to 0.
  - Counters update in the same edge as y_valid.
- When not defined: the port and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package demux_1_4_pkg holds:
  - localparam NUM_OUT=4 and SEL_W=2.
  - Typedef sel_t as logic [SEL_W-1:0].
  - Function onehot4(sel_t) returning logic [3:0].
  - CNT_W=16 for the optional counters.
- One natural sub-module, demux_lane_cnt: a single saturating 16-bit counter with an increment enable. It is instantiated 4 times under DEMUX_1_4_CNT_EN.
- The lane routing stays in the top level.

Test Plan:
- Reset: hold rst_n=0 for 3 edges with in_valid=1, d=1, s=2 → y=0000 and y_valid=0000 throughout.
- Select sweep, DATA_W=1, in_valid=1: (d,s) sequence (0,0),(1,0),(0,1),(1,1),(0,2),(1,2),(0,3),(1,3) → one cycle later y = 0000,0001,0000,0010,0000,0100,0000,1000. y_valid is one-hot(s) each cycle: 0001,0001,0010,0010,0100,0100,1000,1000.
- Idle: in_valid=0 with d=1, s=3 → next cycle y=0000, y_valid=0000.
- Back-to-back with DATA_W=8: d=8'hA5 to s=1, then d=8'h3C to s=2 on consecutive cycles → y lane 1 = A5 (others 0), then lane 2 = 3C (others 0). y_valid 0010 then 0100.
- Reset mid-stream: rst_n=0 for one edge between valid beats → outputs zero that cycle. The next valid beat appears normally one cycle later.
- With DEMUX_1_4_CNT_EN: 5 beats to s=3 and 2 beats to s=0 → lane_cnt lane 3 = 5 and lane 0 = 2, others 0. Preload to 16'hFFFE and send 3 beats → the counter stays at 16'hFFFF.
